// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizing, also consumed by the freepool/RAT rework.
package rename_pkg;

  localparam int NUM_PREG   = 128;
  localparam int NUM_AREG   = 32;
  localparam int PREG_W     = $clog2(NUM_PREG);
  localparam int AREG_W     = $clog2(NUM_AREG);
  localparam int FIFO_DEPTH = NUM_PREG - NUM_AREG;
  localparam int LOW_WATER  = 4;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} alloc_state_e;

  // Pool pointers run 0..FIFO_DEPTH-1, which is not a power of two, so wrap explicitly.
  function automatic preg_t ptr_inc(input preg_t p);
    return (p == preg_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/preg_fifo.sv
// Circular store of free preg numbers; callers are trusted never to push when full or pop when empty.
module preg_fifo
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  preg_t             push_data,
  input  logic              pop,
  output preg_t             pop_data,
  output logic              full,
  output logic              empty,
  output logic [PREG_W-1:0] count
);

  preg_t mem [FIFO_DEPTH];
  preg_t head;
  preg_t tail;

  // Storage is deliberately left unreset; the init sequencer rewrites every entry.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[head];
  assign full     = (count == PREG_W'(FIFO_DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register free pool controller: init sequencing, RENAME grants and RETIRE reclaims.
module preg_alloc_ctrl
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              alloc_req,
  output logic              alloc_grant,
  output preg_t             alloc_preg,
  input  logic              free_valid,
  input  preg_t             free_preg,
  output logic [PREG_W-1:0] free_count,
  output logic              low_water,
  output logic              err
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  preg_t             init_ctr;
  logic              in_run;
  logic              init_last;
  logic              push;
  logic              pop;
  preg_t             push_data;
  preg_t             pop_data;
  logic              full;
  logic              empty;
  logic [PREG_W-1:0] count;
  logic [PREG_W-1:0] count_next;
  logic              bad_zero;
  logic              bad_range;
  logic              overflow;
  logic              free_ok;

  assign in_run    = (state == ST_RUN);
  assign init_last = (init_ctr == preg_t'(NUM_PREG - 1));

  // p0 is x0 and may never re-enter the pool; range guard only matters for non-power-of-2 pools.
  assign bad_zero  = (free_preg == '0);
  assign bad_range = (32'(free_preg) >= 32'(NUM_PREG));

  assign alloc_grant = in_run && alloc_req && !empty;
  assign overflow    = full && !alloc_grant;
  assign free_ok     = in_run && free_valid && !bad_zero && !bad_range && !overflow;

  assign push       = in_run ? free_ok : 1'b1;
  assign push_data  = in_run ? free_preg : init_ctr;
  assign pop        = alloc_grant;
  assign alloc_preg = (in_run && !empty) ? pop_data : '0;
  assign ready      = in_run;
  assign count_next = count + PREG_W'(push) - PREG_W'(pop);

  preg_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Status outputs track the post-edge count; low_water stays quiet until the pool is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_ctr   <= preg_t'(NUM_AREG);
      free_count <= '0;
      low_water  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (!in_run) begin
        init_ctr <= init_ctr + 1'b1;
        if (init_last) state <= ST_RUN;
      end
      free_count <= count_next;
      low_water  <= (in_run || init_last) && (count_next < PREG_W'(LOW_WATER));
      if (in_run && free_valid && (bad_zero || bad_range || overflow)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Self-checking bench for preg_alloc_ctrl against a queue-based model of the free pool.
module tb_preg_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic       alloc_req;
  logic       alloc_grant;
  logic [6:0] alloc_preg;
  logic       free_valid;
  logic [6:0] free_preg;
  logic [6:0] free_count;
  logic       low_water;
  logic       err;

  int total = 0;
  int bad   = 0;

  int pool[$];
  bit run;
  int init_left;
  bit m_err;

  preg_alloc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ready       (ready),
    .alloc_req   (alloc_req),
    .alloc_grant (alloc_grant),
    .alloc_preg  (alloc_preg),
    .free_valid  (free_valid),
    .free_preg   (free_preg),
    .free_count  (free_count),
    .low_water   (low_water),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pool.delete();
    run       = 1'b0;
    init_left = 96;
    m_err     = 1'b0;
  endtask

  // One clock of stimulus: combinational checks before the edge, registered checks after.
  task automatic apply_stimulus(input bit req, input bit fv, input logic [6:0] fp);
    bit g;
    bit full_before;
    int exp_preg;
    int tmp;
    alloc_req  = req;
    free_valid = fv;
    free_preg  = fp;
    #1;
    g        = run && req && (pool.size() != 0);
    exp_preg = (run && pool.size() != 0) ? pool[0] : 0;
    check_output("ready", 32'(ready), 32'(run));
    check_output("grant", 32'(alloc_grant), 32'(g));
    check_output("preg", 32'(alloc_preg), 32'(exp_preg));
    if (!run) begin
      pool.push_back(32 + 96 - init_left);
      init_left--;
      if (init_left == 0) run = 1'b1;
    end else begin
      full_before = (pool.size() == 96);
      if (g) tmp = pool.pop_front();
      if (fv) begin
        if (fp == 7'd0 || (full_before && !g)) m_err = 1'b1;
        else pool.push_back(int'(fp));
      end
    end
    @(posedge clk);
    #1;
    check_output("count", 32'(free_count), 32'(pool.size()));
    check_output("low_water", 32'(low_water), 32'(run && pool.size() < 4));
    check_output("err", 32'(err), 32'(m_err));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n      = 1'b0;
    alloc_req  = 1'b1;
    free_valid = 1'b0;
    free_preg  = 7'd0;
    #1;
    model_reset();
    check_output("rst_ready", 32'(ready), 32'd0);
    check_output("rst_grant", 32'(alloc_grant), 32'd0);
    check_output("rst_preg", 32'(alloc_preg), 32'd0);
    check_output("rst_count", 32'(free_count), 32'd0);
    check_output("rst_low_water", 32'(low_water), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_init(input bit noisy);
    for (int i = 0; i < 96; i++) begin
      if (noisy)
        apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       7'($urandom_range(0, 127)));
      else
        apply_stimulus(1'b0, 1'b0, 7'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_preg  = 7'd0;
    model_reset();

    reset_dut();
    run_init(1'b1);

    // Drain the whole pool, plus one request against an empty pool.
    for (int i = 0; i < 97; i++) apply_stimulus(1'b1, 1'b0, 7'd0);

    // No bypass: the returned preg is only allocatable on the following cycle.
    apply_stimulus(1'b1, 1'b1, 7'd45);
    apply_stimulus(1'b1, 1'b0, 7'd0);

    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 7'(60 + i));
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b1, 7'(40 + i));

    apply_stimulus(1'b0, 1'b1, 7'd0);
    apply_stimulus(1'b0, 1'b0, 7'd0);
    apply_stimulus(1'b1, 1'b1, 7'd77);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     7'(($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 127)));
    end

    // Overflow against a freshly initialised, full pool.
    reset_dut();
    run_init(1'b0);
    apply_stimulus(1'b0, 1'b1, 7'd5);
    apply_stimulus(1'b0, 1'b0, 7'd0);
    apply_stimulus(1'b1, 1'b1, 7'd9);
    apply_stimulus(1'b0, 1'b0, 7'd0);

    // Asynchronous reset in the middle of a cycle after 20 grants.
    reset_dut();
    run_init(1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 7'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_ready", 32'(ready), 32'd0);
    check_output("async_grant", 32'(alloc_grant), 32'd0);
    check_output("async_count", 32'(free_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    alloc_req = 1'b0;
    run_init(1'b1);
    apply_stimulus(1'b1, 1'b0, 7'd0);
    apply_stimulus(1'b1, 1'b0, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
